// File: rtl/snap_phase_pkg.sv
// rtl/snap_phase_pkg.sv - capture FSM state encoding and status word bit positions
package snap_phase_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int DONE_BIT = 31;
  localparam int BUSY_BIT = 30;

endpackage

// File: rtl/snap_phase_edge_det.sv
// rtl/snap_phase_edge_det.sv - rising-edge detector for the software arm level
module snap_phase_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic level_q;

  always_ff @(posedge clk) begin
    if (rst) level_q <= 1'b0;
    else     level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/snap_phase_capture.sv
// rtl/snap_phase_capture.sv - single-shot per-channel phase snapshot into a BRAM
// Optional SNAP_PHASE_EXT_TRIG_EN adds ext_trig gating of the first accepted sample.
module snap_phase_capture
  import snap_phase_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int PHASE_W = 16,
  parameter int CH_W    = 8
) (
  input  logic               user_clk,
  input  logic               user_rst,
  input  logic               start,
  input  logic [CH_W-1:0]    ch_sel,
  input  logic               phase_valid,
  input  logic [CH_W-1:0]    phase_ch,
  input  logic [PHASE_W-1:0] phase_in,
`ifdef SNAP_PHASE_EXT_TRIG_EN
  input  logic               ext_trig,
`endif
  output logic               bram_we,
  output logic [ADDR_W-1:0]  bram_addr,
  output logic [31:0]        bram_din,
  output logic [31:0]        addr_out,
  output logic               busy,
  output logic               done
);

  state_t            state;
  logic [ADDR_W:0]   count;
  logic [CH_W-1:0]   ch_lat;
  logic              start_rise;
  logic              arm;
  logic              match;
  logic              trig_ok;
  logic [31:0]       status;

  snap_phase_edge_det u_edge (
    .clk   (user_clk),
    .rst   (user_rst),
    .level (start),
    .rise  (start_rise)
  );

  assign arm   = start_rise && (state == IDLE || state == DONE);
  assign match = phase_valid && (phase_ch == ch_lat);

`ifdef SNAP_PHASE_EXT_TRIG_EN
  logic trig_seen;

  // The trigger cycle itself counts, so a coincident sample is accepted.
  assign trig_ok = trig_seen | ext_trig;

  always_ff @(posedge user_clk) begin
    if (user_rst)                         trig_seen <= 1'b0;
    else if (arm)                         trig_seen <= 1'b0;
    else if (state == ARMED && ext_trig)  trig_seen <= 1'b1;
  end
`else
  assign trig_ok = 1'b1;
`endif

  always_comb begin
    status           = '0;
    status[ADDR_W:0] = count;
    status[BUSY_BIT] = (state == ARMED) || (state == CAPTURE);
    status[DONE_BIT] = (state == DONE);
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state     <= IDLE;
      count     <= '0;
      ch_lat    <= '0;
      bram_we   <= 1'b0;
      bram_addr <= '0;
      bram_din  <= '0;
      addr_out  <= '0;
    end else begin
      bram_we  <= 1'b0;
      addr_out <= status;
      case (state)
        IDLE, DONE: begin
          if (start_rise) begin
            state  <= ARMED;
            ch_lat <= ch_sel;
            count  <= '0;
          end
        end
        ARMED: begin
          if (match && trig_ok) begin
            bram_we   <= 1'b1;
            bram_addr <= '0;
            bram_din  <= 32'($signed(phase_in));
            count     <= (ADDR_W+1)'(1);
            state     <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (match) begin
            bram_we   <= 1'b1;
            bram_addr <= count[ADDR_W-1:0];
            bram_din  <= 32'($signed(phase_in));
            count     <= count + 1'b1;
            // Last slot filled: stop rather than wrap.
            if (&count[ADDR_W-1:0]) state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = addr_out[BUSY_BIT];
  assign done = addr_out[DONE_BIT];

endmodule

// File: tb/tb_snap_phase_capture.sv
// tb/tb_snap_phase_capture.sv - directed-vector bench for snap_phase_capture
module tb_snap_phase_capture;

  localparam int ADDR_W  = 4;
  localparam int PHASE_W = 16;
  localparam int CH_W    = 8;

  logic               user_clk = 1'b0;
  logic               user_rst = 1'b1;
  logic               start = 1'b0;
  logic [CH_W-1:0]    ch_sel = '0;
  logic               phase_valid = 1'b0;
  logic [CH_W-1:0]    phase_ch = '0;
  logic [PHASE_W-1:0] phase_in = '0;
`ifdef SNAP_PHASE_EXT_TRIG_EN
  logic               ext_trig = 1'b0;
`endif
  logic               bram_we;
  logic [ADDR_W-1:0]  bram_addr;
  logic [31:0]        bram_din;
  logic [31:0]        addr_out;
  logic               busy;
  logic               done;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int n_wr  = 0;
  int          wr_addr [64];
  logic [31:0] wr_din  [64];
  int          wr_cyc  [64];

  always #5 user_clk = ~user_clk;

  snap_phase_capture #(
    .ADDR_W  (ADDR_W),
    .PHASE_W (PHASE_W),
    .CH_W    (CH_W)
  ) dut (
    .user_clk    (user_clk),
    .user_rst    (user_rst),
    .start       (start),
    .ch_sel      (ch_sel),
    .phase_valid (phase_valid),
    .phase_ch    (phase_ch),
    .phase_in    (phase_in),
`ifdef SNAP_PHASE_EXT_TRIG_EN
    .ext_trig    (ext_trig),
`endif
    .bram_we     (bram_we),
    .bram_addr   (bram_addr),
    .bram_din    (bram_din),
    .addr_out    (addr_out),
    .busy        (busy),
    .done        (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock, sample just after the edge and log any BRAM write.
  task automatic step();
    @(posedge user_clk);
    #1;
    cyc++;
    if (bram_we === 1'b1) begin
      if (n_wr < 64) begin
        wr_addr[n_wr] = int'(bram_addr);
        wr_din[n_wr]  = bram_din;
        wr_cyc[n_wr]  = cyc;
      end
      n_wr++;
    end
  endtask

  task automatic arm(input logic [CH_W-1:0] ch);
    phase_valid = 1'b0;
    start = 1'b0;
    step();
    ch_sel = ch;
    start = 1'b1;
    step();
    start = 1'b0;
    n_wr = 0;
  endtask

  initial begin
    int m;
    int guard;
    logic pulsed;

    // Reset state
    repeat (3) step();
    check("rst_we",   32'(bram_we), 32'h0);
    check("rst_addr", 32'(bram_addr), 32'h0);
    check("rst_din",  bram_din, 32'h0);
    check("rst_stat", addr_out, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    user_rst = 1'b0;
    step();

    // Channels cycling 0..7, capturing channel 5
    arm(8'd5);
    check("armed_stat_lag", addr_out, 32'h0);
    m = 0;
    for (int j = 0; j < 136; j++) begin
      phase_valid = 1'b1;
      phase_ch = CH_W'(j % 8);
      if (j % 8 == 5) begin
        phase_in = 16'(16'h1000 + m);
        m++;
      end else begin
        phase_in = 16'h7fff;
      end
      step();
    end
    phase_valid = 1'b0;
    step();
    check("cyc_nwr", 32'(n_wr), 32'd16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("cyc_addr%0d", i), 32'(wr_addr[i]), 32'(i));
      check($sformatf("cyc_din%0d", i), wr_din[i], 32'h1000 + 32'(i));
      if (i > 0) check($sformatf("cyc_gap%0d", i), 32'(wr_cyc[i] - wr_cyc[i-1]), 32'd8);
    end
    check("cyc_stat", addr_out, 32'h8000_0010);
    check("cyc_done", 32'(done), 32'h1);
    check("cyc_busy", 32'(busy), 32'h0);

    // Sign extension and back-to-back matches
    arm(8'd5);
    phase_valid = 1'b1;
    phase_ch = 8'd5;
    phase_in = 16'h8001;
    step();
    check("sext_we",  32'(bram_we), 32'h1);
    check("sext_din", bram_din, 32'hFFFF_8001);
    for (int k = 1; k < 20; k++) begin
      phase_in = 16'(k);
      step();
    end
    phase_valid = 1'b0;
    check("b2b_we_end", 32'(bram_we), 32'h0);
    check("b2b_nwr", 32'(n_wr), 32'd16);
    check("b2b_din1", wr_din[1], 32'h1);
    check("b2b_addr15", 32'(wr_addr[15]), 32'd15);
    check("b2b_span", 32'(wr_cyc[15] - wr_cyc[0]), 32'd15);
    step();
    check("b2b_stat", addr_out, 32'h8000_0010);

    // Re-arm mid-capture is ignored, ch_sel change after arm ignored
    arm(8'd5);
    ch_sel = 8'd3;
    pulsed = 1'b0;
    for (int j = 0; j < 40; j++) begin
      phase_valid = 1'b1;
      phase_ch = 8'd5;
      phase_in = 16'(16'h0200 + j);
      if (n_wr == 7 && !pulsed) begin
        start = 1'b1;
        pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
    end
    phase_valid = 1'b0;
    start = 1'b0;
    step();
    check("rearm_nwr", 32'(n_wr), 32'd16);
    check("rearm_addr7", 32'(wr_addr[7]), 32'd7);
    check("rearm_addr15", 32'(wr_addr[15]), 32'd15);
    check("rearm_done", 32'(done), 32'h1);
    arm(8'd5);
    step();
    check("rearm_stat", addr_out, 32'h4000_0000);
    check("rearm_busy", 32'(busy), 32'h1);

    // Reset during capture
    guard = 0;
    while (n_wr < 3 && guard < 20) begin
      phase_valid = 1'b1;
      phase_ch = 8'd5;
      phase_in = 16'(16'h0300 + guard);
      step();
      guard++;
    end
    check("abort_pre_nwr", 32'(n_wr), 32'd3);
    user_rst = 1'b1;
    step();
    check("abort_we", 32'(bram_we), 32'h0);
    check("abort_stat", addr_out, 32'h0);
    check("abort_nwr", 32'(n_wr), 32'd3);
    user_rst = 1'b0;
    arm(8'd5);
    phase_valid = 1'b1;
    phase_ch = 8'd5;
    phase_in = 16'h0042;
    step();
    phase_valid = 1'b0;
    check("restart_we", 32'(bram_we), 32'h1);
    check("restart_addr", 32'(bram_addr), 32'h0);
    check("restart_din", bram_din, 32'h42);

`ifdef SNAP_PHASE_EXT_TRIG_EN
    // External trigger gates the first sample
    user_rst = 1'b1;
    step();
    user_rst = 1'b0;
    arm(8'd5);
    for (int j = 0; j < 20; j++) begin
      phase_valid = 1'b1;
      phase_ch = 8'd5;
      phase_in = 16'(16'h0500 + j);
      step();
    end
    check("trig_pre_nwr", 32'(n_wr), 32'd0);
    ext_trig = 1'b1;
    phase_in = 16'h0077;
    step();
    ext_trig = 1'b0;
    check("trig_we", 32'(bram_we), 32'h1);
    check("trig_addr", 32'(bram_addr), 32'h0);
    check("trig_din", bram_din, 32'h77);
    phase_in = 16'h0078;
    step();
    phase_valid = 1'b0;
    check("trig_sticky_addr", 32'(bram_addr), 32'h1);
    check("trig_sticky_din", bram_din, 32'h78);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/snap_phase_capture.md
SNAP_PHASE_CAPTURE -- requirements
Module: snap_phase_capture

Interface
REQ-001 Parameter ADDR_W, default 10, log2 of capture depth in samples; legal range 2..29.
REQ-002 Parameter PHASE_W, default 16, phase sample width in bits; legal range 8..32.
REQ-003 Parameter CH_W, default 8, channel index width in bits.
REQ-004 Port user_clk, input, 1: sole clock; all logic is on its rising edge.
REQ-005 Port user_rst, input, 1: reset, synchronous, active-high.
REQ-006 Port start, input, 1: software arm level; only its rising edge acts.
REQ-007 Port ch_sel, input, CH_W: channel to capture; sampled on arm.
REQ-008 Port phase_valid, input, 1: qualifies phase_in and phase_ch this cycle.
REQ-009 Port phase_ch, input, CH_W: channel index of the current sample.
REQ-010 Port phase_in, input, PHASE_W: signed phase sample.
REQ-011 Port bram_we, output, 1: snapshot BRAM write enable.
REQ-012 Port bram_addr, output, ADDR_W: snapshot BRAM write address.
REQ-013 Port bram_din, output, 32: phase_in sign-extended to 32 bits.
REQ-014 Port addr_out, output, 32: status word for the snapPhase_addr software register: bit31 done, bit30 busy, bits[ADDR_W:0] samples written, all other bits 0.
REQ-015 Ports busy, done, outputs, 1 each: copies of addr_out bits 30 and 31.

Function
REQ-016 FSM states: IDLE, ARMED, CAPTURE, DONE.
REQ-017 start rising edge = start high this cycle and low the previous cycle, using one internal register.
REQ-018 A rising edge in IDLE or DONE moves to ARMED, latches ch_sel, and clears the sample count to 0 in the same cycle.
REQ-019 A rising edge in ARMED or CAPTURE is ignored; ch_sel changes after arm are ignored.
REQ-020 A matching sample is phase_valid=1 with phase_ch equal to the latched channel; all other samples are dropped.
REQ-021 In ARMED, the first matching sample is written at address 0, sets count to 1, and moves to CAPTURE.
REQ-022 In CAPTURE, each matching sample is written at address count[ADDR_W-1:0], then count increments.
REQ-023 Latency: bram_we, bram_addr and bram_din are registered; they assert exactly 1 cycle after the matching input cycle.
REQ-024 bram_we is high for exactly 1 cycle per written sample.
REQ-025 The write to address 2^ADDR_W-1 sets count to 2^ADDR_W and moves to DONE; there is no wrap and no further write.
REQ-026 busy = 1 in ARMED and CAPTURE; done = 1 in DONE only.
REQ-027 addr_out is registered and reflects the state/count of the previous cycle.
REQ-028 Back-to-back matching samples on every cycle are accepted without loss.

Reset
REQ-029 While user_rst is high: state IDLE, count 0, edge register 0, bram_we 0, bram_addr 0, bram_din 0, addr_out 0.
REQ-030 user_rst during CAPTURE aborts the capture with no write on the following cycle, and takes precedence over every other event in the same cycle.

Configuration
REQ-031 Macro SNAP_PHASE_EXT_TRIG_EN, when defined, adds input port ext_trig (1 bit).
REQ-032 With SNAP_PHASE_EXT_TRIG_EN defined, ARMED accepts no sample until ext_trig has been seen high; this is held in a sticky flag, set in ARMED, cleared on arm and on reset.
REQ-033 With SNAP_PHASE_EXT_TRIG_EN defined, a matching sample in the same cycle that ext_trig first goes high is accepted.
REQ-034 Without SNAP_PHASE_EXT_TRIG_EN, port ext_trig does not exist, and ARMED accepts the first matching sample.

Structure
REQ-035 Package snap_phase_pkg holds the FSM state enumeration typedef and the addr_out bit-position constants (DONE_BIT=31, BUSY_BIT=30).
REQ-036 Sub-module snap_phase_edge_det implements the start rising-edge detector; all other logic is flat.

Verification
REQ-037 Bench parameters ADDR_W=4, CH_W=8; arm with ch_sel=5; valid on every cycle with phase_ch cycling 0..7 -> 16 writes at addresses 0..15, 8 cycles apart; then done=1 and addr_out=0x80000010.
REQ-038 phase_in=16'h8001 on a matching sample -> bram_din=32'hFFFF8001, 1 cycle later.
REQ-039 Matching valid on every cycle (phase_ch held at 5) -> 16 consecutive bram_we pulses, then bram_we=0.
REQ-040 start pulsed again mid-capture after 7 writes -> ignored; capture completes with 16 writes total; a new edge in DONE -> ARMED with addr_out=0x40000000.
REQ-041 user_rst asserted after 3 writes -> the next cycle has bram_we=0 and addr_out=0; a subsequent arm restarts at address 0.
REQ-042 With SNAP_PHASE_EXT_TRIG_EN: arm, 20 matching samples, then ext_trig pulse -> no writes before the pulse; the first write is the sample coincident with or after the pulse.
